cv32e40p_apu_arbiter: RTL and testbench

//  Shares one APU (FPU/DSP unit) between N_CORES cv32e40p cores (PULP cluster, FPU=1).

---
 rtl/cv32e40p_apu_core_pkg.sv | 7 +
 rtl/cv32e40p_apu_arbiter.sv | 145 ++++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// Payload widths of the cv32e40p APU interface, shared by cores, arbiter and APU.
package cv32e40p_apu_core_pkg;
    parameter int APU_NARGS_CPU    = 3;
    parameter int APU_WOP_CPU      = 6;
    parameter int APU_NDSFLAGS_CPU = 15;
    parameter int APU_NUSFLAGS_CPU = 5;
endpackage

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin share of one APU between N_CORES cores; grant is combinational, responses steered back
// with zero latency via an in-order tag FIFO. A stalled request is locked until the APU grants it.
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int N_CORES         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic [N_CORES-1:0]                                  core_apu_req_i,
    output logic [N_CORES-1:0]                                  core_apu_gnt_o,
    input  logic [N_CORES-1:0][APU_NARGS_CPU-1:0][31:0]         core_apu_operands_i,
    input  logic [N_CORES-1:0][APU_WOP_CPU-1:0]                 core_apu_op_i,
    input  logic [N_CORES-1:0][APU_NDSFLAGS_CPU-1:0]            core_apu_flags_i,
    output logic [N_CORES-1:0]                                  core_apu_rvalid_o,
    output logic [31:0]                                         core_apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                         core_apu_flags_o,
    output logic                                                apu_req_o,
    input  logic                                                apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                      apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                              apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                         apu_flags_o,
    input  logic                                                apu_rvalid_i,
    input  logic [31:0]                                         apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                         apu_flags_i,
    output logic                                                busy_o,
    output logic                                                resp_err_o
);
    localparam int IDW = $clog2(N_CORES);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_q;
    logic [IDW-1:0]     lock_q, lock_d;
    logic [IDW-1:0]     tag_q [MAX_OUTSTANDING];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      cnt_q;
    logic               err_q;

    logic               win_vld;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     cand;
    logic               req;
    logic [IDW-1:0]     gid;
    logic               full;
    logic               push;
    logic               pop;
    logic [IDW-1:0]     head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (cnt_q == CW'(MAX_OUTSTANDING));
    assign head = tag_q[rd_ptr_q];

    // Scan downward so the candidate closest to rr_q is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_id  = rr_q;
        cand    = rr_q;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            cand = IDW'((int'(rr_q) + i) % N_CORES);
            if (core_apu_req_i[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        req     = 1'b0;
        gid     = rr_q;
        case (state_q)
            S_IDLE: begin
                if (!full && win_vld) begin
                    req = 1'b1;
                    gid = win_id;
                    if (!apu_gnt_i) begin
                        state_d = S_WAIT;
                        lock_d  = win_id;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                gid = lock_q;
                if (apu_gnt_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset also gates the combinational handshake outputs so they drop immediately.
    assign apu_req_o = req && rst_ni;
    assign push      = apu_req_o && apu_gnt_i;
    assign pop       = apu_rvalid_i && (cnt_q != '0) && rst_ni;

    assign apu_operands_o = core_apu_operands_i[gid];
    assign apu_op_o       = core_apu_op_i[gid];
    assign apu_flags_o    = core_apu_flags_i[gid];

    always_comb begin
        core_apu_gnt_o    = '0;
        core_apu_rvalid_o = '0;
        if (push) core_apu_gnt_o[gid]     = 1'b1;
        if (pop)  core_apu_rvalid_o[head] = 1'b1;
    end

    assign core_apu_result_o = apu_result_i;
    assign core_apu_flags_o  = apu_flags_i;
    assign busy_o            = apu_req_o || (cnt_q != '0);
    assign resp_err_o        = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            lock_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            if (push) begin
                tag_q[wr_ptr_q] <= gid;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
                rr_q            <= (gid == IDW'(N_CORES - 1)) ? '0 : gid + 1'b1;
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
            if (apu_rvalid_i && (cnt_q == '0)) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Random-stimulus bench for the APU arbiter with a queue-based reference model and response scoreboard.
module tb_cv32e40p_apu_arbiter;
    import cv32e40p_apu_core_pkg::*;
    localparam int N    = 4;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_ni;
    logic [N-1:0]                               core_req;
    logic [N-1:0]                               core_gnt;
    logic [N-1:0][APU_NARGS_CPU-1:0][31:0]      core_ops;
    logic [N-1:0][APU_WOP_CPU-1:0]              core_op;
    logic [N-1:0][APU_NDSFLAGS_CPU-1:0]         core_flg;
    logic [N-1:0]                               core_rv;
    logic [31:0]                                core_res;
    logic [APU_NUSFLAGS_CPU-1:0]                core_uflg;
    logic                                       apu_req;
    logic                                       apu_gnt;
    logic [APU_NARGS_CPU-1:0][31:0]             apu_ops;
    logic [APU_WOP_CPU-1:0]                     apu_op;
    logic [APU_NDSFLAGS_CPU-1:0]                apu_flg;
    logic                                       apu_rv;
    logic [31:0]                                apu_res;
    logic [APU_NUSFLAGS_CPU-1:0]                apu_uflg;
    logic                                       busy;
    logic                                       resp_err;

    always #5 clk = ~clk;

    cv32e40p_apu_arbiter #(.N_CORES(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .core_apu_req_i      (core_req),
        .core_apu_gnt_o      (core_gnt),
        .core_apu_operands_i (core_ops),
        .core_apu_op_i       (core_op),
        .core_apu_flags_i    (core_flg),
        .core_apu_rvalid_o   (core_rv),
        .core_apu_result_o   (core_res),
        .core_apu_flags_o    (core_uflg),
        .apu_req_o           (apu_req),
        .apu_gnt_i           (apu_gnt),
        .apu_operands_o      (apu_ops),
        .apu_op_o            (apu_op),
        .apu_flags_o         (apu_flg),
        .apu_rvalid_i        (apu_rv),
        .apu_result_i        (apu_res),
        .apu_flags_i         (apu_uflg),
        .busy_o              (busy),
        .resp_err_o          (resp_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: priority pointer, pending (stalled) requester, queue of outstanding requester IDs.
    int       next_prio = 0;
    int       pend = -1;
    int       outq[$];
    bit       err_m = 1'b0;
    logic [N-1:0] gnt_seen = '0;
    int       xfers = 0;
    int       rv_issued = 0;

    initial begin
        bit           ereq;
        int           eid;
        int           c;
        logic [N-1:0] egnt;
        logic [N-1:0] erv;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                next_prio = 0;
                pend      = -1;
                outq.delete();
                err_m     = 1'b0;
                gnt_seen  = '0;
                chk("rst_apu_req", 128'(apu_req), 128'(0));
                chk("rst_gnt",     128'(core_gnt), 128'(0));
                chk("rst_rvalid",  128'(core_rv), 128'(0));
                chk("rst_err",     128'(resp_err), 128'(0));
                chk("rst_busy",    128'(busy), 128'(0));
            end else begin
                ereq = 1'b0;
                eid  = 0;
                if (pend >= 0) begin
                    ereq = 1'b1;
                    eid  = pend;
                end else if (outq.size() < MAXO) begin
                    for (int i = 0; i < N; i++) begin
                        c = (next_prio + i) % N;
                        if (core_req[c] && !ereq) begin
                            ereq = 1'b1;
                            eid  = c;
                        end
                    end
                end
                egnt = '0;
                if (ereq && apu_gnt) egnt = N'(1) << eid;
                chk("apu_req", 128'(apu_req), 128'(ereq));
                chk("core_gnt", 128'(core_gnt), 128'(egnt));
                chk("busy", 128'(busy), 128'(ereq || (outq.size() != 0)));
                chk("resp_err", 128'(resp_err), 128'(err_m));
                if (ereq) begin
                    chk("payload_ops",   128'(apu_ops), 128'(core_ops[eid]));
                    chk("payload_op",    128'(apu_op),  128'(core_op[eid]));
                    chk("payload_flags", 128'(apu_flg), 128'(core_flg[eid]));
                end
                erv = '0;
                if (apu_rv) begin
                    if (outq.size() > 0) erv = N'(1) << outq.pop_front();
                    else                 err_m = 1'b1;
                end
                chk("core_rvalid", 128'(core_rv), 128'(erv));
                chk("result_fwd",  128'(core_res), 128'(apu_res));
                chk("uflags_fwd",  128'(core_uflg), 128'(apu_uflg));
                if (ereq && apu_gnt) begin
                    outq.push_back(eid);
                    next_prio = (eid + 1) % N;
                    pend      = -1;
                end else if (ereq) begin
                    pend = eid;
                end
                gnt_seen = core_gnt;
                if (apu_req && apu_gnt) xfers++;
            end
        end
    end

    // One cycle of stimulus: cores hold req+payload until granted; APU answers only issued ops unless forced.
    task automatic cyc(input int preq, input int pgnt, input int prv, input bit force_rv);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (gnt_seen[k]) begin
                core_req[k] = 1'b0;
            end else if (!core_req[k] && ($urandom_range(99) < preq)) begin
                core_req[k] = 1'b1;
                core_ops[k] = {$urandom, $urandom, $urandom};
                core_op[k]  = APU_WOP_CPU'($urandom);
                core_flg[k] = APU_NDSFLAGS_CPU'($urandom);
            end
        end
        apu_gnt  = ($urandom_range(99) < pgnt);
        apu_rv   = 1'b0;
        if (force_rv) begin
            apu_rv = 1'b1;
        end else if ((xfers > rv_issued) && ($urandom_range(99) < prv)) begin
            apu_rv = 1'b1;
            rv_issued++;
        end
        apu_res  = $urandom;
        apu_uflg = APU_NUSFLAGS_CPU'($urandom);
    endtask

    initial begin
        int b;
        rst_ni   = 1'b1;
        core_req = '0;
        core_ops = '0;
        core_op  = '0;
        core_flg = '0;
        apu_gnt  = 1'b0;
        apu_rv   = 1'b0;
        apu_res  = '0;
        apu_uflg = '0;
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        repeat (300) cyc(40, 70, 50, 1'b0);
        repeat (200) cyc(90, 100, 60, 1'b0);
        repeat (150) cyc(60, 20, 40, 1'b0);
        repeat (60)  cyc(90, 100, 0, 1'b0);
        repeat (200) cyc(80, 80, 30, 1'b0);

        b = 0;
        while (((xfers != rv_issued) || (core_req != '0) || busy) && (b < 500)) begin
            cyc(0, 100, 100, 1'b0);
            b++;
        end
        chk("drain_in_time", 128'(b < 500), 128'(1));

        cyc(0, 100, 0, 1'b1);
        repeat (5) cyc(0, 100, 0, 1'b0);
        chk("err_sticky", 128'(resp_err), 128'(1));

        repeat (3) cyc(100, 0, 0, 1'b0);
        chk("wait_req_held", 128'(apu_req), 128'(1));
        #3 rst_ni = 1'b0;
        #1;
        chk("async_rst_req",    128'(apu_req), 128'(0));
        chk("async_rst_gnt",    128'(core_gnt), 128'(0));
        chk("async_rst_rvalid", 128'(core_rv), 128'(0));
        chk("async_rst_err",    128'(resp_err), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rv_issued = xfers;
        rst_ni    = 1'b1;

        repeat (300) cyc(50, 60, 50, 1'b0);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
